// File: rtl/mul_acc_iter_if.sv
// Handshake and operand bundle between the EX stage and the iterative
// multiply-accumulate unit.
interface mul_acc_iter_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic [2:0]            op_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   hilo_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/mul_acc_iter.sv
// Iterative MULT/MADD/MSUB unit, STEP_BITS multiplier bits per cycle.
// Optional MULACC_EARLY_OUT_EN: leave CALC once the remaining multiplier is zero.
module mul_acc_iter #(
    parameter int DATA_W    = 32,
    parameter int STEP_BITS = 8
) (
    input logic           clk,
    input logic           rst,
    mul_acc_iter_if.slave bus
);
    localparam int ITER  = DATA_W / STEP_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int W2    = 2 * DATA_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [DATA_W-1:0] mplier_q;
    logic [W2-1:0]     mcand_q;
    logic [W2-1:0]     partial_q;
    logic [W2-1:0]     hilo_q;
    logic [W2-1:0]     res_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              is_signed;
    logic [DATA_W-1:0] mag1, mag2;
    logic [W2-1:0]     pp, prod, res_nx;
    logic [DATA_W-1:0] mplier_nx;
    logic              calc_last;

    // Operand magnitudes; negating the most negative value wraps to 2^(DATA_W-1),
    // which is exactly the unsigned magnitude we want.
    always_comb begin
        is_signed = (bus.op_i == 3'b000) || (bus.op_i == 3'b010) || (bus.op_i == 3'b100);
        mag1 = (is_signed && bus.opdata1_i[DATA_W-1]) ? ('0 - bus.opdata1_i) : bus.opdata1_i;
        mag2 = (is_signed && bus.opdata2_i[DATA_W-1]) ? ('0 - bus.opdata2_i) : bus.opdata2_i;
    end

    // mcand_q is pre-shifted to the current digit position each cycle.
    always_comb begin
        pp        = mcand_q * {{(W2-STEP_BITS){1'b0}}, mplier_q[STEP_BITS-1:0]};
        mplier_nx = mplier_q >> STEP_BITS;
`ifdef MULACC_EARLY_OUT_EN
        calc_last = (cnt_q == CNT_W'(ITER-1)) || (mplier_nx == '0);
`else
        calc_last = (cnt_q == CNT_W'(ITER-1));
`endif
    end

    always_comb begin
        prod = neg_q ? ('0 - partial_q) : partial_q;
        case (op_q)
            3'b010, 3'b011: res_nx = hilo_q + prod;
            3'b100, 3'b101: res_nx = hilo_q - prod;
            default:        res_nx = prod;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            partial_q <= '0;
            hilo_q    <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
        end else if (bus.annul_i) begin
            state <= IDLE;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    op_q      <= bus.op_i;
                    neg_q     <= is_signed & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                    mcand_q   <= {{DATA_W{1'b0}}, mag1};
                    mplier_q  <= mag2;
                    hilo_q    <= bus.hilo_i;
                    partial_q <= '0;
                    cnt_q     <= '0;
                    state     <= CALC;
                end
                CALC: begin
                    partial_q <= partial_q + pp;
                    mcand_q   <= mcand_q << STEP_BITS;
                    mplier_q  <= mplier_nx;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (calc_last) state <= ACC;
                end
                ACC: begin
                    res_q <= res_nx;
                    state <= DONE;
                end
                default: if (!bus.start_i) begin
                    res_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o  = (state == DONE);
    assign bus.result_o = (state == DONE) ? res_q : '0;
    assign bus.busy_o   = (state == CALC) || (state == ACC);
endmodule

// File: tb/tb_mul_acc_iter.sv
// Directed bench for mul_acc_iter (defaults DATA_W=32, STEP_BITS=8); expected
// latencies follow MULACC_EARLY_OUT_EN when it is defined.
module tb_mul_acc_iter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef MULACC_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mul_acc_iter_if #(.DATA_W(32)) bus ();

    mul_acc_iter #(.DATA_W(32), .STEP_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Cycles from the capture cycle to the first ready_o.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] m;
        int nb, d;
        m  = ((op == 3'd0 || op == 3'd2 || op == 3'd4) && b[31]) ? (32'd0 - b) : b;
        nb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
        d = (nb + 7) / 8;
        if (d < 1) d = 1;
        return EARLY ? (2 + d) : 6;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] h, input logic [63:0] exp);
        int cyc, nbusy, lat;
        lat = exp_lat(op, b);
        bus.op_i = op; bus.opdata1_i = a; bus.opdata2_i = b; bus.hilo_i = h;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        // scramble inputs after capture; the unit must ignore them
        bus.opdata1_i = ~a; bus.opdata2_i = ~b; bus.hilo_i = ~h; bus.op_i = ~op;
        cyc = 1; nbusy = 0;
        while (!bus.ready_o && cyc < 100) begin
            if (bus.busy_o) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " busy cycles"}, 64'(nbusy), 64'(lat - 1));
        chk({tag, " busy at ready"}, 64'(bus.busy_o), 64'd0);
        chk({tag, " result"}, bus.result_o, exp);
        @(posedge clk); #1;
        chk({tag, " held"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, exp[62:0]});
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " release"}, {63'd0, bus.ready_o} | bus.result_o, 64'd0);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.op_i = '0;
        bus.opdata1_i = '0; bus.opdata2_i = '0; bus.hilo_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", bus.result_o, 64'd0);
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("mult -3*5",   3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001);
        run_op("mult minneg", 3'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000);
        run_op("madd",        3'd2, 32'd4, 32'hFFFF_FFFE, 64'h10, 64'h8);
        run_op("msubu",       3'd5, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("msub signed", 3'd4, 32'hFFFF_FFFE, 32'd3, 64'h64, 64'h6A);
        run_op("op110 multu", 3'd6, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h1_FFFF_FFFE);
        run_op("multu x3",    3'd1, 32'h1234_5678, 32'd3, 64'd0, 64'h0000_0000_369D_0368);
        run_op("multu zero",  3'd1, 32'hDEAD_BEEF, 32'd0, 64'd0, 64'd0);

        // annul in the third CALC cycle
        bus.op_i = 3'd0; bus.opdata1_i = 32'h0001_0001; bus.opdata2_i = 32'h0100_0000;
        bus.hilo_i = '0; bus.start_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.annul_i = 1'b1; bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        chk("annul busy", 64'(bus.busy_o), 64'd0);
        chk("annul ready", 64'(bus.ready_o), 64'd0);
        @(posedge clk); #1;
        chk("annul stays idle", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
        run_op("after annul", 3'd1, 32'd7, 32'd6, 64'd0, 64'h2A);

        // async reset during ACC
        bus.op_i = 3'd1; bus.opdata1_i = 32'hFFFF_FFFF; bus.opdata2_i = 32'hFFFF_FFFF;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        chk("in ACC busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b0; bus.start_i = 1'b0;
        #1;
        chk("rst immediate", {62'd0, bus.ready_o, bus.busy_o} | bus.result_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst idles", {62'd0, bus.ready_o, bus.busy_o} | bus.result_o, 64'd0);
        run_op("after rst", 3'd3, 32'd3, 32'd3, 64'h1_0000_0000, 64'h1_0000_0009);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mul_acc_iter.md
# mul_acc_iter

Parametrised iterative multiply-accumulate unit for the EX stage, generalising the current single-cycle multiply plus two-cycle MADD/MSUB path. It performs MULT/MULTU/MADD/MADDU/MSUB/MSUBU over a configurable word width, retiring STEP_BITS multiplier bits per cycle. It uses the same start/ready/annul handshake as the divider, so EX can raise its stall request the same way. The result goes to the HI/LO write path as `{hi, lo}`.

## Interface
- DATA_W, 32, operand width; HI/LO result is 2*DATA_W bits.
- STEP_BITS, 8, multiplier bits retired per CALC cycle; legal values are 1, 2, 4, 8, 16; DATA_W must be a multiple of STEP_BITS.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- start_i  in  1  request; held high until ready_o is seen, then dropped.
- annul_i  in  1  flush; aborts any operation in progress.
- op_i  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU; 110 and 111 execute as MULTU.
- opdata1_i  in  DATA_W  multiplicand.
- opdata2_i  in  DATA_W  multiplier.
- hilo_i  in  2*DATA_W  forwarded {HI,LO} accumulator, used by MADD/MSUB ops.
- result_o  out  2*DATA_W  {HI,LO} result; valid while ready_o=1, zero otherwise.
- ready_o  out  1  result valid.
- busy_o  out  1  high in CALC and ACC.

## Operation
- States: IDLE, CALC, ACC, DONE. Reset forces IDLE with result_o=0, ready_o=0, busy_o=0; all internal registers are cleared.
- IDLE:
  - When start_i=1 and annul_i=0, capture op_i, opdata1_i, opdata2_i and hilo_i, then go to CALC.
  - Signed ops (MULT, MADD, MSUB) capture the two's-complement magnitude of each operand as DATA_W-bit unsigned. -2^(DATA_W-1) becomes 2^(DATA_W-1) and must not overflow.
  - Capture neg = opdata1_i[MSB] ^ opdata2_i[MSB] for signed ops; neg = 0 for unsigned ops.
- CALC:
  - Each cycle: partial += mcand * mplier[STEP_BITS-1:0] shifted to the current digit position; then mplier is shifted right by STEP_BITS and the iteration counter is incremented.
  - After ITER = DATA_W/STEP_BITS cycles, go to ACC.
- ACC:
  - prod = neg ? -partial : partial, all in 2*DATA_W bits.
  - MULT/MULTU: res = prod. MADD/MADDU: res = hilo + prod. MSUB/MSUBU: res = hilo - prod. All modulo 2^(2*DATA_W); no overflow flag is produced.
  - Register res, then go to DONE.
- DONE: ready_o=1 and result_o=res, both held while start_i=1. When start_i=0, go to IDLE, clearing ready_o and result_o on that edge.
- annul_i=1 in any state: next state is IDLE with ready_o=0 and result_o=0. Annul takes priority over start_i and over completion.
- start_i held high in DONE does not restart the unit. A new operation requires start_i to drop for at least one cycle first.
- Input changes after capture are ignored until the next IDLE capture.

## Timing
- Call the capture edge E0. Edges E1..E_ITER are CALC, edge E(ITER+1) is ACC, and ready_o rises after edge E(ITER+1).
- ready_o is first high in cycle ITER+2 counted from the capture cycle. With defaults (DATA_W=32, STEP_BITS=8) that is 6 cycles; with STEP_BITS=1 it is 34 cycles.
- busy_o is high from E0 until the ACC edge.
- EX drives stallreq = start_i & ~ready_o, so the instruction leaves EX in the first cycle that ready_o=1.
- Back-to-back operations: start_i low for one cycle after DONE (return to IDLE), then the next start is accepted. Minimum spacing is ITER+3 cycles.
- Asynchronous rst assertion mid-operation clears all state immediately; operation resumes at the first rising clk edge after rst deasserts.

## Configuration
- MULACC_EARLY_OUT_EN defined: at the end of each CALC cycle, if the shifted-out mplier remainder is zero, go to ACC immediately.
  - Latency becomes 3 + ceil(significant magnitude bits of opdata2 / STEP_BITS) - 1 cycles, with a minimum of 3 cycles (one CALC cycle). opdata2=0 therefore gives ready_o in cycle 3.
  - Results are bit-identical to the non-early-out build.
- Not defined: CALC always runs exactly ITER cycles and latency is fixed.

## Test plan
- MULT, defaults, opdata1=0xFFFFFFFD (-3), opdata2=5 -> result_o=0xFFFFFFFF_FFFFFFF1; ready_o first high in cycle 6; busy_o high for cycles 1-5.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001. MULT 0x80000000*0x80000000 -> 0x40000000_00000000.
- MADD hilo=0x00000000_00000010, 4*0xFFFFFFFE -> 0x00000000_00000008. MSUBU hilo=0, 1*1 -> 0xFFFFFFFF_FFFFFFFF.
- annul_i pulsed in the 3rd CALC cycle -> ready_o never rises and busy_o=0 next cycle. A fresh MULTU 7*6 started two cycles later -> 0x0000002A after the normal latency.
- rst low for one cycle during ACC -> all outputs 0 immediately; the FSM idles until start_i is re-presented.
- MULACC_EARLY_OUT_EN with STEP_BITS=8: MULTU 0x12345678*3 -> 0x00000000_369D0368 with ready_o in cycle 3. The same operands without the macro -> same value in cycle 6.
